// File: rtl/iob_2p_mem_reader_pkg.sv
// Shared types and constants for the two-port memory read streamer.
package iob_2p_mem_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } rd_state_e;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned FifoPtrW  = 2;
    // Wide enough to hold fifo count (0..4) plus one in-flight read.
    localparam int unsigned CreditW   = 3;

endpackage

// File: rtl/iob_mem_rd_fifo.sv
// Four-entry synchronous FIFO buffering memory read data toward the stream.
module iob_mem_rd_fifo
    import iob_2p_mem_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               pop,
    output logic [DATA_W-1:0]  rdata,
    output logic [CreditW-1:0] count,
    output logic               full,
    output logic               empty
);

    logic [DATA_W-1:0]   mem_q [FifoDepth];
    logic [FifoPtrW-1:0] wr_ptr_q;
    logic [FifoPtrW-1:0] rd_ptr_q;
    logic [CreditW-1:0]  count_q;
    logic                do_push;
    logic                do_pop;

    assign full    = (count_q == CreditW'(FifoDepth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + FifoPtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FifoPtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CreditW'(1);
                2'b01:   count_q <= count_q - CreditW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/iob_2p_mem_reader.sv
// Streams len words from a registered-read memory starting at base_addr, with
// credit-based issue into a small buffer so backpressure never drops data.
module iob_2p_mem_reader
    import iob_2p_mem_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam logic [ADDR_W:0]    CntOne    = (ADDR_W + 1)'(1);
    localparam logic [CreditW-1:0] CreditMax = CreditW'(FifoDepth);

    rd_state_e          state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    issued_q;
    logic [ADDR_W:0]    delivered_q;
    logic               rd_pend_q;
    logic [CreditW-1:0] fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               hs;

    // A read is in flight for exactly one cycle; count it as a used credit.
    assign mem_r_en   = (state_q == StRead) && (issued_q < len_q) &&
                        ((fifo_count + CreditW'(rd_pend_q)) < CreditMax);
    assign mem_r_addr = base_q + issued_q[ADDR_W-1:0];
    assign busy       = (state_q == StRead) || (state_q == StDrain);
    assign done       = (state_q == StDone);
    assign out_valid  = !fifo_empty;
    assign hs         = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            rd_pend_q <= mem_r_en;
            if (hs) begin
                delivered_q <= delivered_q + CntOne;
            end
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        base_q      <= base_addr;
                        len_q       <= len;
                        issued_q    <= '0;
                        delivered_q <= '0;
                        state_q     <= (len == '0) ? StDone : StRead;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRead: begin
                    if (mem_r_en) begin
                        issued_q <= issued_q + CntOne;
                        if (issued_q + CntOne == len_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (hs && (delivered_q + CntOne == len_q)) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    iob_mem_rd_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend_q),
        .wdata (mem_data_in),
        .pop   (hs),
        .rdata (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The credit rule guarantees returning data always finds a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_pend_q && fifo_full));

endmodule

// File: tb/tb_iob_2p_mem_reader.sv
// Scoreboard bench: expected addresses/data queued at start, checked by a monitor.
module tb_iob_2p_mem_reader;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, mem_r_en, out_valid;
    logic [AW-1:0] mem_r_addr;
    logic [DW-1:0] mem_data_in = '0;
    logic [DW-1:0] out_data;
    logic          out_ready;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int rd_pulses = 0;

    logic rdy_rand = 1'b0;
    logic rdy_fix = 1'b1;
    logic rnd_bit = 1'b0;
    logic stall_q = 1'b0;
    logic [DW-1:0] held_data = '0;

    assign out_ready = rdy_rand ? rnd_bit : rdy_fix;

    always #5 clk = ~clk;

    iob_2p_mem_reader #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_r_en    (mem_r_en),
        .mem_r_addr  (mem_r_addr),
        .mem_data_in (mem_data_in),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    // Synchronous-read memory: data appears the cycle after r_en.
    always @(posedge clk) begin
        if (mem_r_en) mem_data_in <= mem[mem_r_addr];
    end

    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(0, 1) == 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: address stream, data stream, stream-hold rule, done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (mem_r_en) begin
                rd_pulses++;
                if (exp_addr.size() == 0) check("rd_unexpected", 32'(mem_r_addr), 32'hffff_ffff);
                else check("rd_addr", 32'(mem_r_addr), 32'(exp_addr.pop_front()));
            end
            if (stall_q) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(held_data));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_data.size() == 0) check("out_unexpected", 32'(out_data), 32'hffff_ffff);
                else check("out_data", 32'(out_data), 32'(exp_data.pop_front()));
            end
            stall_q = out_valid && !out_ready;
            held_data = out_data;
            if (done) done_cnt++;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the following cycle.
    task automatic start_xfer(input int b, input int l, input bit accept);
        start = 1'b1;
        base_addr = AW'(b);
        len = (AW + 1)'(l);
        if (accept) begin
            for (int i = 0; i < l; i++) begin
                exp_addr.push_back(AW'(b + i));
                exp_data.push_back(mem[(b + i) % DEPTH]);
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        @(posedge clk);
        #1;
        check({name, "_data_left"}, 32'(exp_data.size()), 32'd0);
        check({name, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({busy, done, mem_r_en, mem_r_addr, out_valid, out_data});
    endfunction

    initial begin
        int d0;
        int p0;
        int h0;
        bit reached;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(16'h100 + i);

        #23 check("reset_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cycle-accurate full-rate transfer.
        d0 = done_cnt;
        start_xfer(0, 4, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 6));
            check($sformatf("t1_valid_c%0d", k), 32'(out_valid), 32'(k >= 3 && k <= 6));
            check($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 7));
            check($sformatf("t1_ren_c%0d", k), 32'(mem_r_en), 32'(k <= 4));
        end
        @(posedge clk);
        #1;
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_data_left", 32'(exp_data.size()), 32'd0);

        // Address wrap.
        start_xfer(62, 4, 1'b1);
        wait_done("wrap", 50);

        // Backpressure: ready low for 10 cycles.
        rdy_fix = 1'b0;
        p0 = rd_pulses;
        start_xfer(5, 8, 1'b1);
        for (int k = 0; k < 10; k++) @(negedge clk);
        @(posedge clk);
        #1;
        check("stall_max_reads", 32'(rd_pulses - p0 <= 4), 32'd1);
        check("stall_some_reads", 32'(rd_pulses - p0 >= 1), 32'd1);
        check("stall_valid", 32'(out_valid), 32'd1);
        rdy_fix = 1'b1;
        wait_done("stall", 60);

        // Zero-length command.
        p0 = rd_pulses;
        start_xfer(7, 0, 1'b1);
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("len0_done_gone", 32'(done), 32'd0);
        check("len0_no_reads", 32'(rd_pulses - p0), 32'd0);
        @(posedge clk);
        #1;

        // Start while busy is ignored.
        d0 = done_cnt;
        start_xfer(20, 6, 1'b1);
        @(posedge clk);
        #1;
        start_xfer(40, 3, 1'b0);
        wait_done("busy_start", 60);
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-transfer after two words.
        h0 = hs_cnt;
        reached = 1'b0;
        start_xfer(30, 8, 1'b1);
        for (int i = 0; i < 40 && !reached; i++) begin
            @(negedge clk);
            if (hs_cnt - h0 >= 2) reached = 1'b1;
        end
        check("rst_two_words", 32'(reached), 32'd1);
        #2 rst_n = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        #1 check("rst_mid_outputs", out_vec(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_after_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        start_xfer(10, 2, 1'b1);
        wait_done("post_rst", 40);

        // Full-depth transfer and random transfers with random backpressure.
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        rdy_rand = 1'b1;
        d0 = done_cnt;
        start_xfer(int'($urandom_range(0, DEPTH - 1)), 64, 1'b1);
        wait_done("full64", 1000);
        check("full64_done_cnt", 32'(done_cnt - d0), 32'd1);
        for (int t = 0; t < 4; t++) begin
            start_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 64)), 1'b1);
            wait_done($sformatf("rand%0d", t), 1000);
        end
        rdy_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
